ddr_score_keeper: RTL



---
 rtl/ddr_score_keeper.sv | 111 +++++++++++
 1 files changed

// File: rtl/ddr_score_keeper.sv
// rtl/ddr_score_keeper.sv - score, combo and max-combo keeper with BCD display select
module ddr_score_keeper #(
  parameter int                  STATE_BITS  = 1,
  parameter logic [STATE_BITS:0] STATE_RESET = 2'b00,
  parameter logic [STATE_BITS:0] STATE_PAUSE = 2'b01,
  parameter logic [STATE_BITS:0] STATE_GAME  = 2'b10,
  parameter int                  PERFECT_PTS = 2,
  parameter int                  GOOD_PTS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STATE_BITS:0]   game_state,
  input  logic                  display_combo_en,
  input  logic                  hit_perfect,
  input  logic                  hit_good,
  input  logic                  hit_miss,
  output logic [15:0]           score_bcd,
  output logic [15:0]           combo_bcd,
  output logic [15:0]           max_combo_bcd,
  output logic [15:0]           display_bcd,
  output logic                  show_combo,
  output logic                  game_active
);

  localparam logic [3:0] PERFECT_ADD = 4'(PERFECT_PTS);
  localparam logic [3:0] GOOD_ADD    = 4'(GOOD_PTS);

  typedef enum logic [1:0] {CLEAR, PLAY, HOLD, SHOW} state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] score;
  logic [15:0] combo;
  logic [15:0] max_combo;
  logic [15:0] combo_inc;

  // Adds a single digit to a 4-digit BCD value; a carry out of the top digit saturates at 9999.
  function automatic logic [15:0] bcd_add(input logic [15:0] a, input logic [3:0] b);
    logic [4:0]  d;
    logic        carry;
    logic [15:0] r;
    carry = 1'b0;
    r     = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, a[i*4 +: 4]} + {1'b0, (i == 0) ? b : 4'd0} + {4'd0, carry};
      if (d > 5'd9) begin
        d     = d - 5'd10;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      r[i*4 +: 4] = d[3:0];
    end
    if (carry) r = 16'h9999;
    return r;
  endfunction

  // Next mode follows game_state; any non-reset, non-game encoding behaves as pause.
  always_comb begin
    state_next = HOLD;
    if (game_state == STATE_RESET)      state_next = CLEAR;
    else if (game_state == STATE_GAME)  state_next = PLAY;
    else if (display_combo_en)          state_next = SHOW;
    else                                state_next = HOLD;
  end

  // Mode register.
  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_next;
  end

  // Incremented combo, shared by perfect and good hits and by the max-combo update.
  always_comb begin
    combo_inc = bcd_add(combo, 4'd1);
  end

  // Counters: cleared in CLEAR, judged only while the registered mode is PLAY.
  always_ff @(posedge clk) begin
    if (rst || state == CLEAR) begin
      score     <= 16'h0000;
      combo     <= 16'h0000;
      max_combo <= 16'h0000;
    end else if (state == PLAY) begin
      if (hit_miss) begin
        combo <= 16'h0000;
      end else if (hit_perfect || hit_good) begin
        score <= bcd_add(score, hit_perfect ? PERFECT_ADD : GOOD_ADD);
        combo <= combo_inc;
        if (combo_inc > max_combo) max_combo <= combo_inc;
      end
    end
  end

  // Display word selected by the current mode.
  always_comb begin
    display_bcd = 16'h0000;
    case (state)
      PLAY, HOLD: display_bcd = score;
      SHOW:       display_bcd = max_combo;
      default:    display_bcd = 16'h0000;
    endcase
  end

  assign score_bcd     = score;
  assign combo_bcd     = combo;
  assign max_combo_bcd = max_combo;
  assign show_combo    = (state == SHOW);
  assign game_active   = (state == PLAY);

endmodule
